i2c_slave_byte: RTL and testbench

//  I2C target (slave) end of the bus driven by i2c_master. Oversamples open-drain SCL/SDA on the

---
 rtl/i2c_slave_pkg.sv | 30 +++
 rtl/i2c_slave_byte_if.sv | 29 ++
 rtl/i2c_line_sync.sv | 33 +++
 rtl/i2c_slave_byte.sv | 210 +++++++++++++++++++++
 tb/tb_i2c_slave_byte.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C byte target.
// Contents: FSM state enum, ACK/NACK bus levels, field widths, address-match helper.
package i2c_slave_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ADDR_W = 7;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_LOAD,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_e;

  // General-call address 0 never matches, even if configured as our own address.
  function automatic logic addr_match(input logic [ADDR_W-1:0] rx_addr,
                                      input logic [ADDR_W-1:0] own_addr);
    return (rx_addr == own_addr) && (rx_addr != '0);
  endfunction

endpackage

// File: rtl/i2c_slave_byte_if.sv
// Bus and byte-interface bundle of the I2C byte target.
// slave modport : pad levels and rd_data in; sda_oen, write strobe, read request, status out.
// master modport: the environment side (pads, upstream byte source/sink).
interface i2c_slave_byte_if;
  import i2c_slave_pkg::*;

  logic              scl_in;
  logic              sda_in;
  logic              sda_oen;
  logic [BYTE_W-1:0] wr_data;
  logic              wr_en;
  logic              rd_req;
  logic [BYTE_W-1:0] rd_data;
  logic              busy;
  logic              flag_start;
  logic              flag_stop;
  logic              flag_nack;

  modport slave (
    input  scl_in, sda_in, rd_data,
    output sda_oen, wr_data, wr_en, rd_req, busy, flag_start, flag_stop, flag_nack
  );

  modport master (
    output scl_in, sda_in, rd_data,
    input  sda_oen, wr_data, wr_en, rd_req, busy, flag_start, flag_stop, flag_nack
  );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizer plus edge detector for one open-drain line.
// Ports: clk, rst (async, active-high), line_i (pad level),
//        level_o (synchronized level), rise_c / fall_c (one-cycle edge indications).
module i2c_line_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Flops reset to 1 (released bus) so reset release shows no false edge on an idle bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], line_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_c  = sync_q[STAGES-1] & ~hist_q;
  assign fall_c  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/i2c_slave_byte.sv
// I2C target with a byte interface: oversamples SCL/SDA, detects START/STOP,
// matches a 7-bit address, ACKs, streams written bytes out and fetches read bytes.
// Ports: clk, rst (async, active-high), bus (i2c_slave_byte_if.slave):
//   scl_in/sda_in pads, sda_oen (0 = pull low), wr_data/wr_en, rd_req/rd_data,
//   busy, flag_start, flag_stop, flag_nack.
module i2c_slave_byte
  import i2c_slave_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  i2c_slave_byte_if.slave bus
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_c, stop_c;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              rw_q, rw_d;
  logic              ack_q, ack_d;
  logic              sda_oen_q, sda_oen_d;
  logic [BYTE_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_req_q, rd_req_d;
  logic              busy_q, busy_d;
  logic              flag_start_q, flag_start_d;
  logic              flag_stop_q, flag_stop_d;
  logic              flag_nack_q, flag_nack_d;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst(rst), .line_i(bus.scl_in),
    .level_o(scl_lvl), .rise_c(scl_rise), .fall_c(scl_fall)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst(rst), .line_i(bus.sda_in),
    .level_o(sda_lvl), .rise_c(sda_rise), .fall_c(sda_fall)
  );

  // SDA moving while SCL is high marks bus conditions rather than data.
  assign start_c = sda_fall & scl_lvl;
  assign stop_c  = sda_rise & scl_lvl;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      full_q       <= 1'b0;
      shift_q      <= '0;
      rw_q         <= 1'b0;
      ack_q        <= I2C_NACK;
      sda_oen_q    <= 1'b1;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      rd_req_q     <= 1'b0;
      busy_q       <= 1'b0;
      flag_start_q <= 1'b0;
      flag_stop_q  <= 1'b0;
      flag_nack_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      full_q       <= full_d;
      shift_q      <= shift_d;
      rw_q         <= rw_d;
      ack_q        <= ack_d;
      sda_oen_q    <= sda_oen_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      rd_req_q     <= rd_req_d;
      busy_q       <= busy_d;
      flag_start_q <= flag_start_d;
      flag_stop_q  <= flag_stop_d;
      flag_nack_q  <= flag_nack_d;
    end
  end

  // Next-state and output logic; START/STOP pre-empt any bit activity.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    full_d       = full_q;
    shift_d      = shift_q;
    rw_d         = rw_q;
    ack_d        = ack_q;
    sda_oen_d    = sda_oen_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = 1'b0;
    rd_req_d     = 1'b0;
    busy_d       = busy_q;
    flag_start_d = 1'b0;
    flag_stop_d  = 1'b0;
    flag_nack_d  = 1'b0;

    if (stop_c) begin
      state_d     = IDLE;
      sda_oen_d   = 1'b1;
      busy_d      = 1'b0;
      flag_stop_d = 1'b1;
    end else if (start_c) begin
      state_d      = ADDR;
      cnt_d        = '0;
      full_d       = 1'b0;
      sda_oen_d    = 1'b1;
      flag_start_d = 1'b1;
    end else begin
      case (state_q)
        ADDR, WR_DATA: begin
          // full_q marks that the 8th bit has been shifted in; act on the following SCL fall.
          if (scl_rise) begin
            shift_d = {shift_q[BYTE_W-2:0], sda_lvl};
            cnt_d   = cnt_q + 3'd1;
            full_d  = (cnt_q == 3'd7);
          end else if (scl_fall && full_q) begin
            full_d = 1'b0;
            cnt_d  = '0;
            if (state_q == ADDR) begin
              rw_d = shift_q[0];
              if (addr_match(shift_q[BYTE_W-1:1], SLAVE_ADDR)) begin
                state_d   = ADDR_ACK;
                sda_oen_d = I2C_ACK;
                busy_d    = 1'b1;
              end else begin
                state_d   = WAIT_STOP;
                sda_oen_d = 1'b1;
                busy_d    = 1'b0;
              end
            end else begin
              wr_data_d = shift_q;
              wr_en_d   = 1'b1;
              sda_oen_d = I2C_ACK;
              state_d   = WR_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!rw_q) begin
              state_d   = WR_DATA;
              sda_oen_d = 1'b1;
            end else begin
              rd_req_d = 1'b1;
              state_d  = RD_LOAD;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_oen_d = 1'b1;
            state_d   = WR_DATA;
          end
        end
        RD_LOAD: begin
          // Upstream answers rd_req one clock later, so skip the cycle rd_req is high.
          if (!rd_req_q) begin
            shift_d   = bus.rd_data;
            sda_oen_d = bus.rd_data[BYTE_W-1];
            cnt_d     = '0;
            state_d   = RD_DATA;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              sda_oen_d = 1'b1;
              state_d   = RD_ACK;
            end else begin
              shift_d   = {shift_q[BYTE_W-2:0], 1'b0};
              sda_oen_d = shift_q[BYTE_W-2];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            ack_d = sda_lvl;
          end else if (scl_fall) begin
            if (ack_q == I2C_NACK) begin
              flag_nack_d = 1'b1;
              state_d     = WAIT_STOP;
            end else begin
              rd_req_d = 1'b1;
              state_d  = RD_LOAD;
            end
          end
        end
        IDLE, WAIT_STOP: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.sda_oen    = sda_oen_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.rd_req     = rd_req_q;
  assign bus.busy       = busy_q;
  assign bus.flag_start = flag_start_q;
  assign bus.flag_stop  = flag_stop_q;
  assign bus.flag_nack  = flag_nack_q;

endmodule

// File: tb/tb_i2c_slave_byte.sv
// Bench for i2c_slave_byte: a bit-level I2C master model on a wired-AND SDA,
// an upstream byte source/sink, and a transaction-level expectation model.
module tb_i2c_slave_byte;
  import i2c_slave_pkg::*;

  localparam int unsigned Q   = 8;       // quarter SCL period in clk cycles
  localparam logic [6:0]  OWN = 7'h50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  always #5 clk = ~clk;

  i2c_slave_byte_if bus ();

  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & bus.sda_oen;

  i2c_slave_byte #(.SLAVE_ADDR(OWN), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Event monitors: monotonic counters and logs, sampled on the falling edge.
  int         wr_cnt    = 0;
  int         start_cnt = 0;
  int         stop_cnt  = 0;
  int         nack_cnt  = 0;
  int         rdreq_cnt = 0;
  int         busy_cyc  = 0;
  logic [7:0] wr_log [256];
  logic [7:0] rd_src [256];

  always @(negedge clk) begin
    if (bus.wr_en) begin
      wr_log[8'(wr_cnt)] = bus.wr_data;
      wr_cnt++;
    end
    if (bus.rd_req) begin
      bus.rd_data = rd_src[8'(rdreq_cnt)];
      rdreq_cnt++;
    end
    if (bus.flag_start) start_cnt++;
    if (bus.flag_stop)  stop_cnt++;
    if (bus.flag_nack)  nack_cnt++;
    if (bus.busy)       busy_cyc++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- bit-level master ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Entered Q after SCL fell; leaves Q after the next SCL fall.
  task automatic bit_xfer(input logic b, output logic s);
    sda_m = b;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    s = bus.sda_in;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic bus_start();
    scl_m = 1'b1;
    sda_m = 1'b0;
    tick(2 * Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    tick(2 * Q);
    sda_m = 1'b0;
    tick(2 * Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b1;
    tick(2 * Q);
    sda_m = 1'b1;
    tick(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic s;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, s);
      b = {b[6:0], s};
    end
    bit_xfer(nack, s);
  endtask

  // Reference rule: only our own non-zero address is acknowledged.
  function automatic logic model_addr_ack(input logic [6:0] a);
    return (a == OWN && a != 7'h00) ? I2C_ACK : I2C_NACK;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst   = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    tick(4);
    n_cmp++;
    if (bus.sda_oen !== 1'b1) begin n_fail++; $display("FAIL reset_sda_oen: got %b want 1", bus.sda_oen); end
    n_cmp++;
    if ({bus.wr_en, bus.rd_req, bus.busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 000", {bus.wr_en, bus.rd_req, bus.busy});
    end
    n_cmp++;
    if ({bus.flag_start, bus.flag_stop, bus.flag_nack} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {bus.flag_start, bus.flag_stop, bus.flag_nack});
    end
    n_cmp++;
    if (bus.wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h want 00", bus.wr_data); end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic do_write(input logic [6:0] a, input int n, input string tag);
    logic [7:0] data [4];
    logic       ack, exp_ack;
    int         w0, s0, p0, b0, exp_wr;
    w0 = wr_cnt; s0 = start_cnt; p0 = stop_cnt; b0 = busy_cyc;
    exp_ack = model_addr_ack(a);
    exp_wr  = (exp_ack == I2C_ACK) ? n : 0;
    bus_start();
    write_byte({a, 1'b0}, ack);
    n_cmp++;
    if (ack !== exp_ack) begin n_fail++; $display("FAIL %s addr_ack a=%h: got %b want %b", tag, a, ack, exp_ack); end
    for (int i = 0; i < exp_wr; i++) begin
      data[i] = 8'($urandom);
      write_byte(data[i], ack);
      n_cmp++;
      if (ack !== I2C_ACK) begin n_fail++; $display("FAIL %s data_ack[%0d]: got %b want 0", tag, i, ack); end
    end
    bus_stop();
    tick(4);
    n_cmp++;
    if (wr_cnt - w0 !== exp_wr) begin n_fail++; $display("FAIL %s wr_en_count: got %0d want %0d", tag, wr_cnt - w0, exp_wr); end
    for (int i = 0; i < exp_wr; i++) begin
      n_cmp++;
      if (wr_log[8'(w0 + i)] !== data[i]) begin
        n_fail++; $display("FAIL %s wr_data[%0d]: got %h want %h", tag, i, wr_log[8'(w0 + i)], data[i]);
      end
    end
    n_cmp++;
    if (start_cnt - s0 !== 1 || stop_cnt - p0 !== 1) begin
      n_fail++; $display("FAIL %s start_stop_flags: got %0d/%0d want 1/1", tag, start_cnt - s0, stop_cnt - p0);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after_stop: got %b want 0", tag, bus.busy); end
    if (exp_ack == I2C_NACK) begin
      n_cmp++;
      if (busy_cyc != b0) begin n_fail++; $display("FAIL %s busy_on_mismatch: got %0d cycles want 0", tag, busy_cyc - b0); end
    end
  endtask

  task automatic do_read(input int n, input logic [7:0] d0, input string tag);
    logic [7:0] data [4];
    logic [7:0] got;
    logic       ack;
    int         r0, k0;
    r0 = rdreq_cnt; k0 = nack_cnt;
    for (int i = 0; i < n; i++) begin
      data[i] = (i == 0) ? d0 : 8'($urandom);
      rd_src[8'(r0 + i)] = data[i];
    end
    bus_start();
    write_byte({OWN, 1'b1}, ack);
    n_cmp++;
    if (ack !== I2C_ACK) begin n_fail++; $display("FAIL %s read_addr_ack: got %b want 0", tag, ack); end
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, got);
      n_cmp++;
      if (got !== data[i]) begin n_fail++; $display("FAIL %s read_byte[%0d]: got %h want %h", tag, i, got, data[i]); end
    end
    tick(2);
    n_cmp++;
    if (bus.sda_oen !== 1'b1) begin n_fail++; $display("FAIL %s released_after_nack: got %b want 1", tag, bus.sda_oen); end
    n_cmp++;
    if (nack_cnt - k0 !== 1) begin n_fail++; $display("FAIL %s flag_nack_count: got %0d want 1", tag, nack_cnt - k0); end
    bus_stop();
    tick(4);
    n_cmp++;
    if (rdreq_cnt - r0 !== n) begin n_fail++; $display("FAIL %s rd_req_count: got %0d want %0d", tag, rdreq_cnt - r0, n); end
  endtask

  task automatic test_write();
    do_write(OWN, 1, "write_one");
    do_write(OWN, 4, "write_multi");
  endtask

  task automatic test_bad_addr();
    logic [6:0] a;
    do_write(7'h51, 1, "bad_addr_51");
    do_write(7'h00, 1, "general_call");
    a = 7'($urandom_range(1, 127));
    if (a == OWN) a = 7'h7F;
    do_write(a, 1, "bad_addr_rand");
  endtask

  task automatic test_read();
    int r0;
    r0 = rdreq_cnt;
    rd_src[8'(r0)]     = 8'h11;
    rd_src[8'(r0 + 1)] = 8'h22;
    rd_src[8'(r0 + 2)] = 8'h33;
    begin
      logic [7:0] got;
      logic       ack;
      logic [7:0] exp [3];
      exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
      bus_start();
      write_byte({OWN, 1'b1}, ack);
      for (int i = 0; i < 3; i++) begin
        read_byte(i == 2, got);
        n_cmp++;
        if (got !== exp[i]) begin n_fail++; $display("FAIL read3 byte[%0d]: got %h want %h", i, got, exp[i]); end
      end
      bus_stop();
      tick(4);
    end
    do_read(2, 8'($urandom), "read_rand");
  endtask

  task automatic test_random_read();
    logic       ack;
    logic [7:0] got;
    int         w0, s0, r0;
    w0 = wr_cnt; s0 = start_cnt; r0 = rdreq_cnt;
    rd_src[8'(r0)] = 8'h9E;
    bus_start();
    write_byte({OWN, 1'b0}, ack);
    write_byte(8'h05, ack);
    bus_rstart();
    write_byte({OWN, 1'b1}, ack);
    n_cmp++;
    if (ack !== I2C_ACK) begin n_fail++; $display("FAIL rnd_read addr_ack: got %b want 0", ack); end
    read_byte(1'b1, got);
    bus_stop();
    tick(4);
    n_cmp++;
    if (got !== 8'h9E) begin n_fail++; $display("FAIL rnd_read byte: got %h want 9e", got); end
    n_cmp++;
    if (wr_cnt - w0 !== 1 || wr_log[8'(w0)] !== 8'h05) begin
      n_fail++; $display("FAIL rnd_read wr: got %0d/%h want 1/05", wr_cnt - w0, wr_log[8'(w0)]);
    end
    n_cmp++;
    if (start_cnt - s0 !== 2) begin n_fail++; $display("FAIL rnd_read flag_start: got %0d want 2", start_cnt - s0); end
  endtask

  task automatic test_rstart_mid_byte();
    logic       ack, s;
    logic [7:0] got, d;
    int         w0, r0;
    w0 = wr_cnt; r0 = rdreq_cnt;
    d = 8'($urandom);
    rd_src[8'(r0)] = d;
    bus_start();
    write_byte({OWN, 1'b0}, ack);
    for (int i = 0; i < 4; i++) bit_xfer(1'($urandom), s);
    bus_rstart();
    n_cmp++;
    if (dut.state_q !== ADDR) begin n_fail++; $display("FAIL rstart_mid state: got %0d want %0d", dut.state_q, ADDR); end
    write_byte({OWN, 1'b1}, ack);
    n_cmp++;
    if (ack !== I2C_ACK) begin n_fail++; $display("FAIL rstart_mid addr_ack: got %b want 0", ack); end
    read_byte(1'b1, got);
    bus_stop();
    tick(4);
    n_cmp++;
    if (got !== d) begin n_fail++; $display("FAIL rstart_mid read: got %h want %h", got, d); end
    n_cmp++;
    if (wr_cnt != w0) begin n_fail++; $display("FAIL rstart_mid wr_en: got %0d want 0", wr_cnt - w0); end
  endtask

  task automatic test_reset_mid_ack();
    logic s;
    logic [7:0] a;
    a = {OWN, 1'b0};
    bus_start();
    for (int i = 7; i >= 0; i--) bit_xfer(a[i], s);
    sda_m = 1'b1;
    tick(1);
    n_cmp++;
    if (bus.sda_oen !== 1'b0) begin n_fail++; $display("FAIL rst_mid ack_driven: got %b want 0", bus.sda_oen); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.sda_oen !== 1'b1) begin n_fail++; $display("FAIL rst_mid sda_release: got %b want 1", bus.sda_oen); end
    n_cmp++;
    if ({bus.busy, bus.wr_en, bus.rd_req, bus.flag_start, bus.flag_stop, bus.flag_nack} !== 6'b0) begin
      n_fail++; $display("FAIL rst_mid outputs: got %b want 000000",
                         {bus.busy, bus.wr_en, bus.rd_req, bus.flag_start, bus.flag_stop, bus.flag_nack});
    end
    tick(2);
    scl_m = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(4);
    do_write(OWN, 1, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        logic [6:0] a;
        a = ($urandom_range(0, 2) != 0) ? OWN : 7'($urandom_range(0, 127));
        do_write(a, int'($urandom_range(1, 3)), "b2b_write");
      end else begin
        do_read(int'($urandom_range(1, 3)), 8'($urandom), "b2b_read");
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bad_addr();
    test_read();
    test_random_read();
    test_rstart_mid_byte();
    test_reset_mid_ack();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
